// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the MEMORY stage (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle byte/half/word data memory with configurable wait states,
// load extension and error reporting for misaligned/out-of-range accesses.
module dmem_ctrl #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef logic [31:0] mem_t [DEPTH];

  function automatic mem_t memInit();
    for (int i = 0; i < DEPTH; i++) memInit[i] = 32'(i);
  endfunction

  // Contents survive reset; only the power-up image sets word i = i.
  mem_t mem_q = memInit();

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic               we_q, uns_q;
  logic [1:0]         size_q;
  logic [IDX_W+1:0]   addr_q;
  logic [31:0]        wdata_q;
  logic               rspErr_q, rspErr_d;
  logic [31:0]        rspRdata_q, rspRdata_d;

  logic               accept, doOp, reqErr, sizeErr, idxOk;
  logic               opWe, opUns;
  logic [1:0]         opSize;
  logic [IDX_W+1:0]   opAddr;
  logic [31:0]        opWdata;
  logic [IDX_W-1:0]   opIdx;
  logic [31:0]        memWord, shifted, loadData, storeWord;

  always_comb begin
    sizeErr = 1'b0;
    case (bus.req_size)
      2'd1:    sizeErr = bus.req_addr[0];
      2'd2:    sizeErr = (bus.req_addr[1:0] != 2'b00);
      2'd3:    sizeErr = 1'b1;
      default: sizeErr = 1'b0;
    endcase
    idxOk  = ({2'b00, bus.req_addr[ADDR_W-1:2]} < ADDR_W'(DEPTH));
    reqErr = sizeErr || !idxOk;
  end

  // With no wait states the operation happens on the accept edge, so it
  // must see the live request rather than the latched copy.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      opWe    = bus.req_we;
      opUns   = bus.req_unsigned;
      opSize  = bus.req_size;
      opAddr  = bus.req_addr[IDX_W+1:0];
      opWdata = bus.req_wdata;
    end else begin
      opWe    = we_q;
      opUns   = uns_q;
      opSize  = size_q;
      opAddr  = addr_q;
      opWdata = wdata_q;
    end
  end

  always_comb begin
    opIdx     = opAddr[IDX_W+1:2];
    memWord   = mem_q[opIdx];
    shifted   = memWord >> {opAddr[1:0], 3'b000};
    loadData  = memWord;
    storeWord = memWord;
    case (opSize)
      2'd0: begin
        loadData = opUns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        storeWord[{opAddr[1:0], 3'b000} +: 8] = opWdata[7:0];
      end
      2'd1: begin
        loadData = opUns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        storeWord[{opAddr[1], 4'b0000} +: 16] = opWdata[15:0];
      end
      default: begin
        loadData  = memWord;
        storeWord = opWdata;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    accept     = 1'b0;
    doOp       = 1'b0;
    rspErr_d   = 1'b0;
    rspRdata_d = 32'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (reqErr) begin
            state_d  = RESP;
            rspErr_d = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            doOp       = 1'b1;
            state_d    = RESP;
            rspRdata_d = opWe ? 32'b0 : loadData;
          end else begin
            state_d   = WAIT;
            waitCnt_d = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (waitCnt_q == '0) begin
          doOp       = 1'b1;
          state_d    = RESP;
          rspRdata_d = opWe ? 32'b0 : loadData;
        end else begin
          waitCnt_d = waitCnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b0;
      addr_q     <= '0;
      wdata_q    <= 32'b0;
      rspErr_q   <= 1'b0;
      rspRdata_q <= 32'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      rspErr_q   <= rspErr_d;
      rspRdata_q <= rspRdata_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr[IDX_W+1:0];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // A reset coinciding with the commit edge wins, so the write is dropped.
  always_ff @(posedge clk) begin
    if (rst && doOp && opWe) mem_q[opIdx] <= storeWord;
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rspRdata_q;
  assign bus.rsp_err   = rspErr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a 2-wait-state instance for the main tests
// and a zero-wait-state instance for back-to-back throughput.
module tb_dmem_ctrl;

  localparam int WAIT_N = 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sbQ[$];
  logic [31:0] mdl [128];

  dmem_ctrl_if #(.ADDR_W(32)) bus ();
  dmem_ctrl_if #(.ADDR_W(32)) bus0 ();

  dmem_ctrl #(.DEPTH(128), .WAIT_CYCLES(WAIT_N), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  dmem_ctrl #(.DEPTH(128), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog");
  end

  // Issue one request on the main instance, queue its expectation and
  // report what came back; callers pop the scoreboard and compare.
  task automatic sendReq(input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] eData, input logic eErr, input string nm,
                         output logic got, output int lat, output logic [31:0] rdata,
                         output logic rerr, output logic clean);
    logic readyLow;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    sbQ.push_back('{data: eData, err: eErr, lat: (eErr ? 1 : WAIT_N + 1), name: nm});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_size  = 2'd3;
    bus.req_addr  = 32'hFFFF_FFFC;
    bus.req_wdata = 32'hBAD0_BAD0;
    got = 1'b0; lat = 1; rdata = 32'b0; rerr = 1'b0; readyLow = 1'b0; clean = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) readyLow = !bus.req_ready && bus.busy;
      if (bus.rsp_valid) begin
        got = 1'b1; rdata = bus.rsp_rdata; rerr = bus.rsp_err;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (got) begin
      @(negedge clk);
      clean = readyLow && !bus.rsp_valid && (bus.rsp_rdata == 32'b0) &&
              !bus.rsp_err && bus.req_ready && !bus.busy;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'b0; bus.req_wdata = 32'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_size = 2'd0;
    bus0.req_unsigned = 1'b0; bus0.req_addr = 32'b0; bus0.req_wdata = 32'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    vectors++;
    if ({bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_err} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got ready/busy/valid/err=%b required 1000",
               {bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_err});
    end
    vectors++;
    if (bus.rsp_rdata !== 32'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdata: got %h required 00000000", bus.rsp_rdata);
    end
    vectors++;
    if ({bus0.req_ready, bus0.busy, bus0.rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL reset_flags_w0: got ready/busy/valid=%b required 100",
               {bus0.req_ready, bus0.busy, bus0.rsp_valid});
    end
  endtask

  // Table-driven request list shared shape for the functional tests.
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] eData;
    logic        eErr;
    string       nm;
  } vec_t;

  task automatic test_loads_stores();
    vec_t tbl[$];
    logic got, rerr, clean;
    int lat;
    logic [31:0] rdata;
    exp_t e;
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h0000_0004, 1'b0, "lw_10"});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h21, 32'h1234_56A5, 32'h0,         1'b0, "sb_21"});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h0000_A508, 1'b0, "lw_20a"});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h21, 32'h0,        32'hFFFF_FFA5, 1'b0, "lb_21"});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h21, 32'h0,        32'h0000_00A5, 1'b0, "lbu_21"});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, 32'h0,         1'b0, "sh_22"});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'hFFFF_8001, 1'b0, "lh_22"});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        32'h0000_8001, 1'b0, "lhu_22"});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h8001_A508, 1'b0, "lw_20b"});
    foreach (tbl[i]) begin
      sendReq(tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
              tbl[i].eData, tbl[i].eErr, tbl[i].nm, got, lat, rdata, rerr, clean);
      e = sbQ.pop_front();
      vectors++;
      if (!got || lat != e.lat) begin
        miscompares++;
        $display("[TB] FAIL %s_latency: got %0d (seen=%0b) required %0d", e.name, lat, got, e.lat);
      end
      vectors++;
      if ({rerr, rdata} !== {e.err, e.data}) begin
        miscompares++;
        $display("[TB] FAIL %s_data: got err=%b data=%h required err=%b data=%h",
                 e.name, rerr, rdata, e.err, e.data);
      end
      vectors++;
      if (clean !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL %s_handshake: got %b required 1", e.name, clean);
      end
    end
  endtask

  task automatic test_errors();
    vec_t tbl[$];
    logic got, rerr, clean;
    int lat;
    logic [31:0] rdata;
    exp_t e;
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h22,  32'h0,         32'h0,          1'b1, "lw_mis"});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h21,  32'h0,         32'h0,          1'b1, "lh_mis"});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'h0,          1'b1, "sw_oor"});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h30,  32'h0,         32'h0,          1'b1, "size3"});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,         32'h0,          1'b0, "lw_w0"});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0,         32'h0000_007F,  1'b0, "lw_w127"});
    foreach (tbl[i]) begin
      sendReq(tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
              tbl[i].eData, tbl[i].eErr, tbl[i].nm, got, lat, rdata, rerr, clean);
      e = sbQ.pop_front();
      vectors++;
      if (!got || lat != e.lat) begin
        miscompares++;
        $display("[TB] FAIL %s_latency: got %0d (seen=%0b) required %0d", e.name, lat, got, e.lat);
      end
      vectors++;
      if ({rerr, rdata} !== {e.err, e.data}) begin
        miscompares++;
        $display("[TB] FAIL %s_data: got err=%b data=%h required err=%b data=%h",
                 e.name, rerr, rdata, e.err, e.data);
      end
    end
  endtask

  // Store aborted by reset: extraEdges selects which WAIT edge carries the reset.
  task automatic test_reset_abort(input logic [31:0] a, input int extraEdges,
                                  input logic [31:0] eData, input string nm);
    logic got, rerr, clean, seen;
    int lat;
    logic [31:0] rdata;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = a; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (extraEdges) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL %s_ready: got ready/valid=%b required 10", nm, {bus.req_ready, bus.rsp_valid});
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_no_rsp: got response=%b required 0", nm, seen);
    end
    sendReq(1'b0, 2'd2, 1'b0, a, 32'h0, eData, 1'b0, nm, got, lat, rdata, rerr, clean);
    e = sbQ.pop_front();
    vectors++;
    if (!got || {rerr, rdata} !== {e.err, e.data}) begin
      miscompares++;
      $display("[TB] FAIL %s_readback: got seen=%b err=%b data=%h required err=%b data=%h",
               e.name, got, rerr, rdata, e.err, e.data);
    end
  endtask

  function automatic logic [31:0] mdlLoad(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mdl[a[8:2]];
    case (a[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    if (sz == 2'd0) return u ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'd1) return u ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  task automatic mdlStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    w = mdl[a[8:2]];
    if (sz == 2'd2) w = wd;
    else if (sz == 2'd1) begin
      if (a[1]) w[31:16] = wd[15:0]; else w[15:0] = wd[15:0];
    end else begin
      case (a[1:0])
        2'd0: w[7:0]   = wd[7:0];
        2'd1: w[15:8]  = wd[7:0];
        2'd2: w[23:16] = wd[7:0];
        default: w[31:24] = wd[7:0];
      endcase
    end
    mdl[a[8:2]] = w;
  endtask

  task automatic test_random();
    logic got, rerr, clean, we, u;
    logic [1:0] sz;
    logic [31:0] a, wd, ex;
    int lat;
    logic [31:0] rdata;
    exp_t e;
    for (int i = 0; i < 128; i++) mdl[i] = 32'(i);
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      a  = 32'((64 + $urandom_range(0, 7)) * 4);
      if (sz == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
      if (sz == 2'd1) a[1]   = 1'($urandom_range(0, 1));
      wd = $urandom;
      ex = we ? 32'h0 : mdlLoad(a, sz, u);
      sendReq(we, sz, u, a, wd, ex, 1'b0, $sformatf("rand%0d", i), got, lat, rdata, rerr, clean);
      if (we) mdlStore(a, sz, wd);
      e = sbQ.pop_front();
      vectors++;
      if (!got || lat != e.lat || {rerr, rdata} !== {e.err, e.data}) begin
        miscompares++;
        $display("[TB] FAIL %s: got seen=%b lat=%0d err=%b data=%h required lat=%0d err=%b data=%h",
                 e.name, got, lat, rerr, rdata, e.lat, e.err, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_size = 2'd2;
    bus0.req_unsigned = 1'b0; bus0.req_addr = 32'h0;
    sbQ.push_back('{data: 32'h0, err: 1'b0, lat: 1, name: "b2b_first"});
    sbQ.push_back('{data: 32'h1, err: 1'b0, lat: 1, name: "b2b_second"});
    @(posedge clk);
    #1;
    bus0.req_addr = 32'h4;
    @(negedge clk);
    e = sbQ.pop_front();
    vectors++;
    if ({bus0.rsp_valid, bus0.req_ready, bus0.rsp_err, bus0.rsp_rdata} !== {2'b10, e.err, e.data}) begin
      miscompares++;
      $display("[TB] FAIL %s: got valid=%b ready=%b err=%b data=%h required valid=1 ready=0 err=%b data=%h",
               e.name, bus0.rsp_valid, bus0.req_ready, bus0.rsp_err, bus0.rsp_rdata, e.err, e.data);
    end
    @(negedge clk);
    vectors++;
    if ({bus0.rsp_valid, bus0.req_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL b2b_gap: got valid/ready=%b required 01", {bus0.rsp_valid, bus0.req_ready});
    end
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    e = sbQ.pop_front();
    vectors++;
    if ({bus0.rsp_valid, bus0.req_ready, bus0.rsp_err, bus0.rsp_rdata} !== {2'b10, e.err, e.data}) begin
      miscompares++;
      $display("[TB] FAIL %s: got valid=%b ready=%b err=%b data=%h required valid=1 ready=0 err=%b data=%h",
               e.name, bus0.rsp_valid, bus0.req_ready, bus0.rsp_err, bus0.rsp_rdata, e.err, e.data);
    end
    @(negedge clk);
    vectors++;
    if ({bus0.rsp_valid, bus0.req_ready, bus0.rsp_rdata} !== {2'b01, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle: got valid=%b ready=%b data=%h required valid=0 ready=1 data=00000000",
               bus0.rsp_valid, bus0.req_ready, bus0.rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_loads_stores();
    test_errors();
    test_reset_abort(32'h40, 0, 32'h0000_0010, "abort_wait");
    test_reset_abort(32'h44, 1, 32'h0000_0011, "abort_commit");
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised multi-cycle data memory with a valid/ready request port and a single-cycle response pulse. It replaces the combinational word-only data memory in the core's MEMORY stage. It adds byte/halfword/word accesses, sign/zero extension on loads, configurable wait states, and error reporting for misaligned or out-of-range accesses. The core stalls on req_ready/rsp_valid.

Parameters:
DEPTH, 128, number of 32-bit words (power of two not required)
WAIT_CYCLES, 2, extra access cycles between accept and memory operation (0 allowed)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 halfword, 2 word, 3 illegal
req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend; ignored for stores
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid: misaligned, out-of-range or illegal size
busy  out  1  inverse of req_ready

Behaviour:
- Storage: DEPTH x 32 array, little-endian byte lanes; word index = req_addr[ADDR_W-1:2]. Initialised at time zero to word i = i. Reset never clears the array.
- Reset (rst=0 at edge): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request cleared. req_ready=1 in the first cycle after reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1, the request is accepted and we, size, unsigned, addr, wdata are latched. Any other edge stays in IDLE.
- Error check at accept: error if size==3, if size==1 with addr[0]!=0, if size==2 with addr[1:0]!=0, or if word index >= DEPTH. An error goes directly to RESP with rsp_err=1 and rsp_rdata=0. No array access is made.
- Legal request with WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1. In WAIT, decrement each edge. On the edge where counter==0, perform the operation and go to RESP.
- Legal request with WAIT_CYCLES==0: perform the operation on the accept edge and go to RESP.
- Operation (single edge):
  - Store writes only the addressed lanes: byte lane addr[1:0], half lanes addr[1]*2..+1, or all four. Other lanes are unchanged.
  - Load captures the lane(s), extends to 32 bits and registers the result into rsp_rdata.
- RESP: rsp_valid=1 for exactly this cycle, with no backpressure. The next edge returns to IDLE and clears rsp_valid, rsp_err and rsp_rdata.
- Latency: rsp_valid is high in the cycle starting WAIT_CYCLES+1 edges after accept for legal requests, and 1 edge after accept for errors.
- Throughput: at most one request per WAIT_CYCLES+2 cycles.
- req_* inputs are ignored outside IDLE. Changes to them after accept have no effect.
- Reset mid-operation: a reset in WAIT aborts the request. No write occurs and no response is issued. A reset on the same edge as the commit takes priority, so the write is suppressed.
- A store is visible to a load accepted any time after its RESP cycle.

Test Plan:
- Default params, reset, then lw (size 2) at 0x10 -> req_ready drops after accept; rsp_valid high exactly 3 cycles after accept edge; rsp_rdata=0x00000004, rsp_err=0.
- sb wdata=0x123456A5 at 0x21, then lw 0x20 -> store rsp_rdata=0, rsp_err=0; load returns 0x0000A508.
- After the previous store: lb 0x21 -> 0xFFFFFFA5; lbu 0x21 -> 0x000000A5; sh 0x8001 at 0x22 then lh 0x22 -> 0xFFFF8001, lhu -> 0x00008001, lw 0x20 -> 0x8001A508.
- Errors:
  - lw at 0x22 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_rdata=0.
  - sw at 0x200 (index 128) -> rsp_err=1, with word 0 reading back 0 and word 127 reading back 127 afterward (array unchanged).
  - size=3 -> rsp_err=1.
- sw 0xDEADBEEF at 0x40, rst=0 for one edge during first WAIT cycle -> no rsp_valid; req_ready=1 next cycle; lw 0x40 returns 0x00000010.
- WAIT_CYCLES=0 instance: back-to-back lw 0x0 / lw 0x4 with req_valid held high -> rsp pulses 2 cycles apart with data 0 then 1; second accept occurs only in the IDLE cycle after the first RESP.
